// File: rtl/aes_state_engine.sv
// aes_state_engine: iterative AES-128 engine, one round per clock, with an on-chip round-key store.
// Latency: 10 cycles from an accepted command to the registered ready pulse (key load, encrypt, decrypt).
// Backpressure: none; enable is ignored while BUSY, so the controller waits for ready.
// Ports: clk/rst (sync, active-low); key/data/func/enable command inputs; result/ready registered outputs.
// Build option: AES_DECRYPT_EN adds the inverse cipher; without it func=3 completes with result=0.
module aes_state_engine #(
  parameter int NK = 4,
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB*32-1:0]  key,
  input  logic [NB*32-1:0]  data,
  input  logic [1:0]        func,
  input  logic              enable,
  output logic [NB*32-1:0]  result,
  output logic              ready
);
  localparam int NR = NK + 6;
  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic {IDLE, BUSY} fsm_e;
  typedef enum logic [1:0] {OP_KEY, OP_ENC, OP_DEC} op_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte 4c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                           gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                           gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                           gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction
`endif

  function automatic logic [7:0] rcon(input logic [3:0] step);
    case (step)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t = {w3[23:0], w3[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  op_e          op_q, op_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] result_q, result_d;
  logic         ready_q, ready_d;
  logic [127:0] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_wa;
  logic [127:0] rk_wd;
  logic [127:0] round_out;
  logic [127:0] enc_sr;

  assign enc_sr = shift_rows(sub_bytes(state_q));

`ifdef AES_DECRYPT_EN
  // Decrypt walks the key store downwards while the counter still counts up.
  logic [3:0]   dec_idx;
  logic [127:0] dec_ark;
  assign dec_idx = LAST - cnt_q;
  assign dec_ark = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_q[dec_idx];
`endif

  // During key expansion state_q carries the previous round key, so no store read is needed.
  always_comb begin
    round_out = '0;
    case (op_q)
      OP_KEY: round_out = key_step(state_q, rcon(cnt_q));
      OP_ENC: round_out = ((cnt_q == LAST) ? enc_sr : mix_columns(enc_sr)) ^ rk_q[cnt_q];
`ifdef AES_DECRYPT_EN
      OP_DEC: round_out = (cnt_q == LAST) ? dec_ark : inv_mix_columns(dec_ark);
`endif
      default: round_out = '0;
    endcase
  end

  always_comb begin
    fsm_d    = fsm_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    result_d = result_q;
    ready_d  = 1'b0;
    rk_we    = 1'b0;
    rk_wa    = cnt_q;
    rk_wd    = round_out;
    case (fsm_q)
      IDLE: begin
        if (enable && (func != 2'd0)) begin
          fsm_d = BUSY;
          cnt_d = 4'd1;
          case (func)
            2'd1: begin
              op_d    = OP_KEY;
              state_d = key;
              rk_we   = 1'b1;
              rk_wa   = 4'd0;
              rk_wd   = key;
            end
            2'd2: begin
              op_d    = OP_ENC;
              state_d = data ^ rk_q[0];
            end
            default: begin
              op_d    = OP_DEC;
`ifdef AES_DECRYPT_EN
              state_d = data ^ rk_q[LAST];
`else
              state_d = '0;
`endif
            end
          endcase
        end
      end
      BUSY: begin
        state_d = round_out;
        rk_we   = (op_q == OP_KEY);
        if (cnt_q == LAST) begin
          fsm_d    = IDLE;
          cnt_d    = 4'd0;
          ready_d  = 1'b1;
          result_d = (op_q == OP_KEY) ? '0 : round_out;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q    <= IDLE;
      op_q     <= OP_KEY;
      cnt_q    <= '0;
      state_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      fsm_q    <= fsm_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      if (rk_we) rk_q[rk_wa] <= rk_wd;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_aes_state_engine.sv
// tb_aes_state_engine: known-answer table, randomized blocks against a byte-array AES model,
// and hand-written protocol sequences (nop, busy enable, back-to-back, reset mid-operation).
// Decrypt expectations follow AES_DECRYPT_EN so the same bench covers both builds.
module tb_aes_state_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key, data, result;
  logic [1:0]   func;
  logic         enable, ready;
  int           checks = 0;
  int           failures = 0;

`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_state_engine dut (
    .clk(clk), .rst(rst), .key(key), .data(data), .func(func),
    .enable(enable), .result(result), .ready(ready)
  );

  typedef struct {
    logic [1:0]   f;
    logic [127:0] k;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;

  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] mrk [11];

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Walk the field with generator 3 and its inverse in lockstep to fill the S-box.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_zero_keys();
    for (int r = 0; r < 11; r++) mrk[r] = '0;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] d);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8] ^ mrk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul(t[4*c], 2) ^ mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(t[4*c+1], 2) ^ mul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2], 2) ^ mul(t[4*c+3], 3);
          s[4*c+3] = mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3], 2);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ mrk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] d);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8] ^ mrk[10][127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*((c+j)%4)+j] = s[4*c+j];
      for (int i = 0; i < 16; i++) t[i] = isb[t[i]] ^ mrk[r][127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul(t[4*c], 14) ^ mul(t[4*c+1], 11) ^ mul(t[4*c+2], 13) ^ mul(t[4*c+3], 9);
          s[4*c+1] = mul(t[4*c], 9) ^ mul(t[4*c+1], 14) ^ mul(t[4*c+2], 11) ^ mul(t[4*c+3], 13);
          s[4*c+2] = mul(t[4*c], 13) ^ mul(t[4*c+1], 9) ^ mul(t[4*c+2], 14) ^ mul(t[4*c+3], 11);
          s[4*c+3] = mul(t[4*c], 11) ^ mul(t[4*c+1], 13) ^ mul(t[4*c+2], 9) ^ mul(t[4*c+3], 14);
        end
      end else begin
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts and ends at a falling edge; lat counts rising edges from acceptance to visible ready.
  task automatic run_cmd(input logic [1:0] f, input logic [127:0] k, input logic [127:0] d,
                         output logic [127:0] res, output int lat);
    func = f; key = k; data = d; enable = 1'b1;
    @(posedge clk); @(negedge clk);
    enable = 1'b0; func = 2'd0; key = ~k; data = ~d;
    lat = -1;
    res = 'x;
    for (int n = 0; n <= 20; n++) begin
      if (ready === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    vec_t         tbl [6];
    logic [127:0] res, d, ct, pa, pb, k;
    int           lat, nrdy;

    build_sbox();
    rst = 1'b0; enable = 1'b0; func = 2'd0; key = '0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check128("reset_result", result, '0);
    check128("reset_ready", {127'd0, ready}, '0);
    rst = 1'b1;

    // Unloaded (all-zero) key store
    model_zero_keys();
    d = rand128();
    run_cmd(2'd2, '0, d, res, lat);
    check128("zero_store_enc", res, model_enc(d));
    check_int("zero_store_enc_lat", lat, 10);
    run_cmd(2'd3, '0, d, res, lat);
    check128("zero_store_dec", res, DEC_EN ? model_dec(d) : 128'd0);
    check_int("zero_store_dec_lat", lat, 10);

    // Known-answer table
    tbl[0] = '{2'd1, 128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h0};
    tbl[1] = '{2'd2, 128'h0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[2] = '{2'd3, 128'h0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               DEC_EN ? 128'h00112233445566778899aabbccddeeff : 128'h0};
    tbl[3] = '{2'd1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hffff, 128'h0};
    tbl[4] = '{2'd2, 128'h0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[5] = '{2'd3, 128'h0, 128'h3925841d02dc09fbdc118597196a0b32,
               DEC_EN ? 128'h3243f6a8885a308d313198a2e0370734 : 128'h0};
    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].f, tbl[i].k, tbl[i].d, res, lat);
      check128($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check_int($sformatf("vec%0d_latency", i), lat, 10);
      if (tbl[i].f == 2'd1) begin
        model_expand(tbl[i].k);
        check128($sformatf("vec%0d_rk10_model", i), dut.rk_q[10], mrk[10]);
      end
      if (i == 3) check128("fips_rk10", dut.rk_q[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    end

    // Randomized key with four blocks, one key load
    k = rand128();
    run_cmd(2'd1, k, rand128(), res, lat);
    model_expand(k);
    check128("rand_keyload_result", res, '0);
    for (int b = 0; b < 4; b++) begin
      d = rand128();
      run_cmd(2'd2, '0, d, ct, lat);
      check128($sformatf("rand%0d_enc", b), ct, model_enc(d));
      check_int($sformatf("rand%0d_enc_lat", b), lat, 10);
      run_cmd(2'd3, '0, ct, res, lat);
      check128($sformatf("rand%0d_roundtrip", b), res, DEC_EN ? d : 128'd0);
      check_int($sformatf("rand%0d_dec_lat", b), lat, 10);
    end

    // func = 0 is a nop
    func = 2'd0; data = rand128(); enable = 1'b1;
    @(posedge clk); @(negedge clk);
    enable = 1'b0;
    nrdy = 0;
    repeat (15) begin
      if (ready) nrdy++;
      @(posedge clk); @(negedge clk);
    end
    check_int("nop_no_ready", nrdy, 0);

    // enable while busy is ignored
    pa = rand128();
    pb = rand128();
    func = 2'd2; data = pa; enable = 1'b1;
    @(posedge clk); @(negedge clk);
    enable = 1'b0; func = 2'd0; data = '0;
    lat = -1; nrdy = 0; res = 'x;
    for (int n = 0; n <= 25; n++) begin
      if (ready === 1'b1) begin
        nrdy++;
        if (lat < 0) begin
          lat = n;
          res = result;
        end
      end
      if (n == 3) begin func = 2'd2; data = pb; enable = 1'b1; end
      if (n == 4) begin enable = 1'b0; func = 2'd0; end
      @(posedge clk); @(negedge clk);
    end
    check128("busy_enable_result", res, model_enc(pa));
    check_int("busy_enable_lat", lat, 10);
    check_int("busy_enable_single_ready", nrdy, 1);

    // New command issued in the ready cycle, then single-cycle ready and held result
    run_cmd(2'd2, '0, pa, res, lat);
    check128("b2b_first", res, model_enc(pa));
    run_cmd(2'd2, '0, pb, res, lat);
    check128("b2b_second", res, model_enc(pb));
    check_int("b2b_second_lat", lat, 10);
    @(posedge clk); @(negedge clk);
    check128("ready_one_cycle", {127'd0, ready}, '0);
    check128("result_held", result, model_enc(pb));

    // Reset mid key-load aborts and clears the store
    func = 2'd1; key = rand128(); enable = 1'b1;
    @(posedge clk); @(negedge clk);
    enable = 1'b0; func = 2'd0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    nrdy = 0;
    repeat (15) begin
      if (ready) nrdy++;
      @(posedge clk); @(negedge clk);
    end
    check_int("midreset_no_ready", nrdy, 0);
    check128("midreset_result", result, '0);
    check128("midreset_ready", {127'd0, ready}, '0);
    model_zero_keys();
    d = rand128();
    run_cmd(2'd2, '0, d, res, lat);
    check128("midreset_store_cleared", res, model_enc(d));
    check_int("midreset_enc_lat", lat, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_state_engine.md
# aes_state_engine

Iterative AES-128 engine: one cipher round per clock, with an on-chip round-key store loaded by an explicit key-expansion command. It serves a controller that issues key-load, encrypt and decrypt commands as single-cycle pulses and waits for a one-cycle done pulse. Implementations are area-minimal: no round pipelining, one shared round datapath per direction.

## Interface
- NK, 4: key length in 32-bit words. Only 4 (AES-128, Nr = 10) is supported.
- NB, 4: block length in 32-bit words; fixed at 4 (128-bit block).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- key  in  128  cipher key; sampled only on a key-load command
- data  in  128  plaintext (encrypt) or ciphertext (decrypt); sampled only on the command cycle
- func  in  2  command: 0 = nop, 1 = key expansion, 2 = encrypt, 3 = decrypt
- enable  in  1  command strobe; sampled at a rising edge
- result  out  128  cipher output; valid while ready = 1
- ready  out  1  one-cycle completion pulse

## Operation
- Byte order: bits [127:120] are byte 0 (FIPS-197 input byte in0). The state is column-major: bytes 0..3 form column 0.
- States: IDLE and BUSY; a round counter runs 0..10.
- IDLE, enable = 1, func = 0: ignored, no ready pulse.
- IDLE, enable = 1, func = 1:
  - Store key as rk[0] and enter BUSY.
  - Generate rk[1]..rk[10] one per cycle with the FIPS-197 schedule (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
  - result = 0 at completion.
- IDLE, enable = 1, func = 2:
  - state = data ^ rk[0].
  - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk[r]).
  - Round 10 omits MixColumns.
- IDLE, enable = 1, func = 3:
  - state = data ^ rk[10].
  - Rounds 9..1: InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), InvMixColumns.
  - Final round: InvShiftRows, InvSubBytes, AddRoundKey(rk[0]).
- S-box and inverse S-box are combinational (ROM or GF(2^8)-inversion logic).
- enable while BUSY: ignored, including func and data changes; the in-progress command completes unaffected.
- Round keys persist until the next key-load command or reset.
- Encrypt/decrypt before any key load uses the reset (all-zero) round-key store. This is deterministic but is not the AES result for a zero key.
- Reset:
  - result = 0, ready = 0, state IDLE, counter 0, round-key store all zeros.
  - Reset asserted mid-operation aborts it; no ready pulse follows.

## Timing
- Command accepted at edge E (enable = 1, IDLE).
- Ten further edges perform rounds or key steps 1..10.
- result and ready are registered at edge E+10 and visible in the cycle after it. Latency is 10 cycles for all of func 1, 2, 3.
- ready is high for exactly one cycle; result holds its value until the next completion or reset.
- Engine returns to IDLE with ready; a new enable in the ready cycle is accepted.
- No output has combinational dependence on any input.

## Configuration
- AES_DECRYPT_EN defined: func = 3 performs the inverse cipher as above.
- AES_DECRYPT_EN undefined:
  - Inverse S-box, InvMixColumns and the inverse datapath are omitted.
  - func = 3 still pulses ready after 10 cycles, with result = 0.
  - Key expansion and encrypt are unchanged.

## Test plan
- Reset mid-operation: key-load, then reset low for 1 cycle mid-BUSY.
  - No ready pulse; result = 0; ready = 0.
- Key-load key = 000102030405060708090a0b0c0d0e0f; encrypt 00112233445566778899aabbccddeeff.
  - Required result: 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Decrypting that result returns the plaintext.
  - Each ready arrives exactly 10 cycles after its enable.
- Key-load key = 2b7e151628aed2a6abf7158809cf4f3c; check stored rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Encrypt 3243f6a8885a308d313198a2e0370734 gives 3925841d02dc09fbdc118597196a0b32.
  - Decrypt gives back the plaintext.
- Multiple blocks, one key-load:
  - Encrypt/decrypt loops over 4 different blocks with the key loaded once.
  - Every pair round-trips.
  - Ciphertexts match a software AES model.
- Protocol:
  - Pulse enable with func = 0: no ready.
  - Pulse enable again mid-encrypt with different data: result unchanged, single ready.
  - enable in the ready cycle: new command accepted.
- Build without AES_DECRYPT_EN:
  - func = 3 gives result 0 with ready at 10 cycles.
  - Encrypt vectors above still pass.
